fft_agu: RTL and testbench
==========================

Name: fft_agu

Overview:
Address generation unit for the in-place radix-2 DIT FFT engine. Sequences all log2(FFT_SIZE) stages × FFT_SIZE/2 butterflies. For each butterfly it emits the two data-memory addresses and drives the twiddle ROM address one cycle ahead, so the registered ROM output aligns with bfly_valid. Sits between the FFT controller (start/done) and the butterfly datapath; directly feeds twiddle_rom.

Parameters:
FFT_SIZE, 4096, transform length; power of two, ≥ 4
LOG2N, $clog2(FFT_SIZE), address width and stage count
TW_AW, LOG2N-1, twiddle address width (NUM_TWIDDLES = FFT_SIZE/2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a transform when IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final butterfly handshake
bfly_valid  output  1  addr_a/addr_b/stage valid; twiddle ROM data valid this cycle
bfly_ready  input  1  datapath accepts the current butterfly
addr_a  output  LOG2N  top-leg data address
addr_b  output  LOG2N  bottom-leg data address (addr_a + 2^stage)
stage  output  $clog2(LOG2N)  current stage index, 0..LOG2N-1
last_in_stage  output  1  current butterfly is index FFT_SIZE/2-1 of its stage
twiddle_addr  output  TW_AW  to twiddle_rom; 1-cycle read latency

Behaviour:
- Reset: state=IDLE. busy, done, bfly_valid, last_in_stage = 0. addr_a, addr_b, stage, twiddle_addr = 0. Internal counters j, s = 0.
- Address math, stage s, butterfly j in 0..FFT_SIZE/2-1:
  - half = 1<<s; pos = j & (half-1); group = j >> s
  - addr_a = (group << (s+1)) | pos; addr_b = addr_a | half
  - tw(s,j) = pos << (TW_AW - s), truncated to TW_AW bits
- fire = bfly_valid & bfly_ready.
- States:
  - IDLE: on start, load j=0, s=0, go to PRIME. Start is ignored in any other state.
  - PRIME: one cycle. twiddle_addr = tw(0,0). Next state RUN.
  - RUN: bfly_valid = 1. Outputs reflect (s,j).
    - On fire: advance j; at j = FFT_SIZE/2-1, wrap j to 0 and increment s.
    - On fire of (LOG2N-1, FFT_SIZE/2-1): go to DONE.
  - DONE: done = 1 for one cycle; busy drops the same cycle; next state IDLE.
- Twiddle lookahead: twiddle_addr is combinational, fire ? tw(next s,j) : tw(s,j). ROM output therefore always matches the (s,j) presented with bfly_valid. There are no bubbles between butterflies or between stages.
- Backpressure: with bfly_ready=0, addr_a, addr_b, stage, last_in_stage and twiddle_addr hold, so the ROM output holds. bfly_valid is never withdrawn without fire.
- Throughput: one butterfly per cycle. Total LOG2N·FFT_SIZE/2 handshakes. Latency start→first bfly_valid = 2 cycles.
- rst mid-transform: returns to IDLE next edge with all outputs at reset values; no done pulse.
- start coincident with rst: rst wins.

Optional Feature:
AGU_STAGE_BARRIER_EN
- Defined: adds input stage_clear (1 bit) and state BARRIER.
  - After the fire of last_in_stage in stages 0..LOG2N-2, the FSM enters BARRIER with bfly_valid=0 and twiddle_addr = tw(s+1,0).
  - It waits for stage_clear=1, then returns to RUN. This protects read-after-write hazards in the in-place memory.
  - stage_clear is ignored outside BARRIER.
- Undefined: no port, no state; stages run back-to-back.

Decomposition:
- Shared header fft_defs.vh: FFT_SIZE, LOG2N, NUM_TWIDDLES and the FSM state encodings (IDLE, PRIME, RUN, BARRIER, DONE).
- One natural sub-module: fft_agu_addr_calc, combinational (s, j) → addr_a, addr_b, tw. It is instantiated twice: once for the current index, once for the lookahead index.

Test Plan:
- start with bfly_ready tied 1 → first bfly_valid 2 cycles later. Stage 0: j=0 gives a=0, b=1, tw=0; j=1 gives a=2, b=3, tw=0. Stage 1: j=1 gives a=1, b=3, tw=1024. Stage 11: j=5 gives a=5, b=2053, tw=5. Exactly 24576 fires, then a single done pulse.
- Scoreboard twiddle ROM douta against the model cos/sin table at every fire, including the first fire of each stage → zero mismatches.
- bfly_ready low for 3 cycles at stage 3, j=7 → addr_a=7, addr_b=15, twiddle_addr and douta stable; the next fire yields j=8.
- start pulsed while busy, and start coincident with rst → ignored; transform count and done timing unchanged.
- rst asserted at stage 5, j=100 → next cycle all outputs 0, no done. A new start then restarts from (0,0).
- AGU_STAGE_BARRIER_EN defined, stage_clear held low 10 cycles after stage 0 ends → bfly_valid=0 and twiddle_addr=0 throughout. After stage_clear=1, the first stage-1 butterfly is a=0, b=2.

Source files
------------

// File: rtl/fft_agu_pkg.sv
// fft_agu_pkg
//   Shared definitions for the radix-2 DIT FFT address generation unit:
//   default transform length, FSM state encoding and a stage-width helper.
//   Optional feature macro used by fft_agu: AGU_STAGE_BARRIER_EN.
package fft_agu_pkg;

  localparam int FFT_SIZE_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_RUN     = 3'd2,
    ST_BARRIER = 3'd3,
    ST_DONE    = 3'd4
  } agu_state_e;

  // Width of the stage index; never below one bit.
  function automatic int stage_width(input int log2n);
    return (log2n > 2) ? $clog2(log2n) : 1;
  endfunction

endpackage

// File: rtl/fft_agu_addr_calc.sv
// fft_agu_addr_calc
//   Combinational butterfly address math for stage s, butterfly j.
//   Ports:
//     i_s      stage index
//     i_j      butterfly index within the stage, 0..N/2-1
//     o_addr_a top-leg address: j with a zero bit inserted at position s
//     o_addr_b bottom-leg address: o_addr_a with bit s set
//     o_tw     twiddle ROM address: (j mod 2^s) << (TW_AW - s)
module fft_agu_addr_calc
  import fft_agu_pkg::*;
#(
  parameter int LOG2N = 12,
  parameter int SW    = stage_width(LOG2N),
  parameter int TW_AW = LOG2N - 1
) (
  input  logic [SW-1:0]    i_s,
  input  logic [TW_AW-1:0] i_j,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [TW_AW-1:0] o_tw
);

  logic [LOG2N-1:0]   w_half;
  logic [LOG2N-1:0]   w_j;
  logic [LOG2N-1:0]   w_pos;
  logic [LOG2N-1:0]   w_group;
  logic [2*LOG2N-1:0] w_pos_wide;

  assign w_half   = LOG2N'(1) << i_s;
  assign w_j      = {1'b0, i_j};
  assign w_pos    = w_j & (w_half - LOG2N'(1));
  assign w_group  = w_j >> i_s;
  assign o_addr_a = ((w_group << i_s) << 1) | w_pos;
  assign o_addr_b = o_addr_a | w_half;

  // pos << (TW_AW - s) written as (pos << TW_AW) >> s so the shift amount
  // never goes negative; pos < 2^s keeps the result inside TW_AW bits.
  assign w_pos_wide = {{LOG2N{1'b0}}, w_pos};
  assign o_tw       = TW_AW'((w_pos_wide << TW_AW) >> i_s);

endmodule

// File: rtl/fft_agu.sv
// fft_agu
//   Address generation unit for the in-place radix-2 DIT FFT. Walks all
//   LOG2N stages x FFT_SIZE/2 butterflies, one per handshake, and drives the
//   twiddle ROM address one cycle ahead so registered ROM data lines up with
//   bfly_valid.
//   Optional feature: define AGU_STAGE_BARRIER_EN to add the stage_clear
//   input and a BARRIER state between stages.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             one-cycle pulse, accepted only in IDLE
//     busy, done        transform in progress / one-cycle completion pulse
//     bfly_valid/ready  butterfly handshake
//     addr_a, addr_b    data-memory addresses of the current butterfly
//     stage             current stage index
//     last_in_stage     current butterfly is the last of its stage
//     twiddle_addr      twiddle ROM address (1-cycle read latency)
//     stage_clear       (barrier build only) releases the inter-stage barrier
//
//   state   | meaning
//   IDLE    | waiting for start
//   PRIME   | one cycle to present tw(0,0) to the ROM
//   RUN     | butterfly presented, advances on fire
//   BARRIER | between stages, waits for stage_clear (barrier build only)
//   DONE    | one-cycle done pulse
module fft_agu
  import fft_agu_pkg::*;
#(
  parameter int FFT_SIZE = FFT_SIZE_DEFAULT,
  parameter int LOG2N    = $clog2(FFT_SIZE),
  parameter int TW_AW    = LOG2N - 1,
  parameter int SW       = stage_width(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bfly_valid,
  input  logic             bfly_ready,
`ifdef AGU_STAGE_BARRIER_EN
  input  logic             stage_clear,
`endif
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [SW-1:0]    stage,
  output logic             last_in_stage,
  output logic [TW_AW-1:0] twiddle_addr
);

  localparam logic [TW_AW-1:0] J_LAST = {TW_AW{1'b1}};
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);

  agu_state_e       r_state;
  agu_state_e       w_next_state;
  logic [SW-1:0]    r_s;
  logic [SW-1:0]    w_ns;
  logic [TW_AW-1:0] r_j;
  logic [TW_AW-1:0] w_nj;
  logic             w_fire;
  logic             w_j_last;
  logic             w_s_last;
  logic [LOG2N-1:0] w_addr_a;
  logic [LOG2N-1:0] w_addr_b;
  logic [TW_AW-1:0] w_tw_cur;
  logic [TW_AW-1:0] w_tw_nxt;
  logic [LOG2N-1:0] w_unused_nxt_addr_a;
  logic [LOG2N-1:0] w_unused_nxt_addr_b;

  assign w_j_last = (r_j == J_LAST);
  assign w_s_last = (r_s == S_LAST);
  assign w_fire   = (r_state == ST_RUN) && bfly_ready;

  // Index after the current handshake. FFT_SIZE/2 is a power of two, so j
  // wraps to 0 on its own; the final butterfly wraps the stage back to 0 too,
  // leaving the counters at their idle value.
  always_comb begin
    w_nj = r_j + TW_AW'(1);
    w_ns = r_s;
    if (w_j_last) begin
      w_ns = w_s_last ? '0 : r_s + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= '0;
      r_j <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_s <= '0;
      r_j <= '0;
    end else if (w_fire) begin
      r_s <= w_ns;
      r_j <= w_nj;
    end
  end

  fft_agu_addr_calc #(.LOG2N(LOG2N), .SW(SW), .TW_AW(TW_AW)) u_cur (
    .i_s      (r_s),
    .i_j      (r_j),
    .o_addr_a (w_addr_a),
    .o_addr_b (w_addr_b),
    .o_tw     (w_tw_cur)
  );

  fft_agu_addr_calc #(.LOG2N(LOG2N), .SW(SW), .TW_AW(TW_AW)) u_nxt (
    .i_s      (w_ns),
    .i_j      (w_nj),
    .o_addr_a (w_unused_nxt_addr_a),
    .o_addr_b (w_unused_nxt_addr_b),
    .o_tw     (w_tw_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_PRIME;
      ST_PRIME: w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_fire && w_j_last) begin
          if (w_s_last) begin
            w_next_state = ST_DONE;
          end else begin
`ifdef AGU_STAGE_BARRIER_EN
            w_next_state = ST_BARRIER;
`else
            w_next_state = ST_RUN;
`endif
          end
        end
      end
`ifdef AGU_STAGE_BARRIER_EN
      ST_BARRIER: if (stage_clear) w_next_state = ST_RUN;
`endif
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Addresses are driven only while a butterfly is presented. The twiddle
  // address is never gated: in PRIME and BARRIER the counters already hold
  // the next butterfly (j=0), whose twiddle is what the ROM must fetch.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    bfly_valid    = 1'b0;
    last_in_stage = 1'b0;
    addr_a        = '0;
    addr_b        = '0;
    stage         = '0;
    twiddle_addr  = w_fire ? w_tw_nxt : w_tw_cur;
    case (r_state)
      ST_PRIME:   busy = 1'b1;
      ST_BARRIER: busy = 1'b1;
      ST_RUN: begin
        busy          = 1'b1;
        bfly_valid    = 1'b1;
        last_in_stage = w_j_last;
        addr_a        = w_addr_a;
        addr_b        = w_addr_b;
        stage         = r_s;
      end
      ST_DONE:    done = 1'b1;
      default:    busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fft_agu.sv
// tb_fft_agu
//   Randomized-backpressure bench for fft_agu (FFT_SIZE = 4096). A
//   transaction-level model tracks how many butterflies have completed and
//   derives every expected output from that count with plain arithmetic.
//   Builds with or without AGU_STAGE_BARRIER_EN.
module tb_fft_agu;

  localparam int N     = 4096;
  localparam int HALFN = N / 2;
  localparam int LOGN  = 12;
  localparam int TOTAL = LOGN * HALFN;
`ifdef AGU_STAGE_BARRIER_EN
  localparam bit BARRIER_EN = 1'b1;
`else
  localparam bit BARRIER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, bfly_ready, stage_clear;
  logic        busy, done, bfly_valid, last_in_stage;
  logic [11:0] addr_a, addr_b;
  logic [3:0]  stage;
  logic [10:0] twiddle_addr;
  logic [10:0] r_rom;

  int n_cmp = 0;
  int n_bad = 0;
  int m_phase = 0;   // 0 idle, 1 prime, 2 run, 3 barrier, 4 done
  int m_k = 0;       // butterflies completed in the current transform
  int obs_fires = 0;
  int obs_dones = 0;
  int hold_cnt = 0;
  int clr_hold = 0;
  int rdy_mode = 0;

  int lit_k [5] = '{0, 1, 2049, 6151, 22533};
  int lit_a [5] = '{0, 2, 1, 7, 5};
  int lit_b [5] = '{1, 3, 3, 15, 2053};
  int lit_s [5] = '{0, 0, 1, 3, 11};
  int lit_tw[5] = '{0, 0, 1024, 1792, 5};

  always #5 clk = ~clk;

  fft_agu dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .bfly_valid   (bfly_valid),
    .bfly_ready   (bfly_ready),
`ifdef AGU_STAGE_BARRIER_EN
    .stage_clear  (stage_clear),
`endif
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .stage        (stage),
    .last_in_stage(last_in_stage),
    .twiddle_addr (twiddle_addr)
  );

  // Twiddle ROM stand-in: one-cycle registered read returning its address.
  always @(posedge clk) r_rom <= twiddle_addr;

  function automatic int f_a(input int s, input int j);
    int h;
    h = 2 ** s;
    return (j / h) * 2 * h + (j % h);
  endfunction

  function automatic int f_tw(input int s, input int j);
    int h;
    h = 2 ** s;
    return (j % h) * (HALFN / h);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int  e_s, e_j, nk, e_a, e_b, e_tw;
    bit  live, e_valid;
    live    = (m_phase == 2) || (m_phase == 3);
    e_valid = (m_phase == 2);
    e_s     = live ? m_k / HALFN : 0;
    e_j     = live ? m_k % HALFN : 0;
    e_a     = e_valid ? f_a(e_s, e_j) : 0;
    e_b     = e_valid ? f_a(e_s, e_j) + 2 ** e_s : 0;
    nk      = (e_valid && bfly_ready) ? m_k + 1 : m_k;
    if (nk == TOTAL) nk = 0;
    e_tw    = live ? f_tw(nk / HALFN, nk % HALFN) : 0;

    chk("busy", int'(busy), int'(m_phase >= 1 && m_phase <= 3));
    chk("done", int'(done), int'(m_phase == 4));
    chk("bfly_valid", int'(bfly_valid), int'(e_valid));
    chk("addr_a", int'(addr_a), e_a);
    chk("addr_b", int'(addr_b), e_b);
    chk("stage", int'(stage), e_valid ? e_s : 0);
    chk("last_in_stage", int'(last_in_stage), int'(e_valid && e_j == HALFN - 1));
    chk("twiddle_addr", int'(twiddle_addr), e_tw);
    if (e_valid) begin
      chk("rom_douta", int'(r_rom), f_tw(e_s, e_j));
      for (int i = 0; i < 5; i++) begin
        if (m_k == lit_k[i]) begin
          chk("lit_addr_a", int'(addr_a), lit_a[i]);
          chk("lit_addr_b", int'(addr_b), lit_b[i]);
          chk("lit_stage", int'(stage), lit_s[i]);
          chk("lit_rom", int'(r_rom), lit_tw[i]);
        end
      end
    end

    if (bfly_valid && bfly_ready) obs_fires <= obs_fires + 1;
    if (done) obs_dones <= obs_dones + 1;

    if (rst) begin
      m_phase <= 0;
      m_k     <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase <= 1; m_k <= 0; end
        1: m_phase <= 2;
        2: if (bfly_ready) begin
          if (m_k + 1 == TOTAL) begin
            m_k     <= 0;
            m_phase <= 4;
          end else begin
            m_k <= m_k + 1;
            if (BARRIER_EN && ((m_k + 1) % HALFN == 0)) m_phase <= 3;
          end
        end
        3: if (stage_clear) m_phase <= 2;
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (hold_cnt > 0) begin
      bfly_ready = 1'b0;
      hold_cnt--;
    end else if (rdy_mode == 1) begin
      bfly_ready = 1'b1;
    end else begin
      bfly_ready = ($urandom_range(0, 99) < 85);
    end
    if (clr_hold > 0) begin
      stage_clear = 1'b0;
      clr_hold--;
    end else begin
      stage_clear = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic run_full(input string name, input int mode, input bit do_bp);
    int cycles, f0;
    bit seen, bp_done, bar_done;
    rdy_mode = mode;
    f0       = obs_fires;
    seen     = 1'b0;
    bp_done  = 1'b0;
    bar_done = 1'b0;
    cycles   = 0;
    start    = 1'b1;
    while (!seen && cycles < 45000) begin
      tick();
      cycles++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (m_phase == 2 && m_k == 1000) start = 1'b1;
        if (do_bp && !bp_done && m_phase == 2 && m_k == 6151) begin
          bfly_ready = 1'b0;
          hold_cnt   = 2;
          bp_done    = 1'b1;
        end
        if (!bar_done && m_phase == 3 && m_k == HALFN) begin
          stage_clear = 1'b0;
          clr_hold    = 9;
          bar_done    = 1'b1;
        end
      end
    end
    if (!seen) begin
      chk({name, "_done_timeout"}, cycles, -1);
    end else begin
      chk({name, "_fire_count"}, obs_fires - f0, TOTAL);
`ifndef AGU_STAGE_BARRIER_EN
      if (mode == 1) chk({name, "_done_latency"}, cycles, TOTAL + 2);
`endif
    end
  endtask

  task automatic run_abort(input int at_k);
    int cycles;
    rdy_mode = 0;
    cycles   = 0;
    start    = 1'b1;
    while (!(m_phase == 2 && m_k == at_k) && cycles < 30000) begin
      tick();
      cycles++;
    end
    if (cycles >= 30000) begin
      chk("abort_reach_timeout", cycles, -1);
    end else begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(bfly_valid), 0);
      chk("abort_addr_b", int'(addr_b), 0);
      chk("abort_twiddle", int'(twiddle_addr), 0);
      repeat (5) tick();
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bfly_ready  = 1'b0;
    stage_clear = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_addr_b", int'(addr_b), 0);

    run_full("xfer_random_bp", 0, 1'b1);
    repeat (4) tick();
    run_abort(5 * HALFN + 100);
    run_full("xfer_full_rate", 1, 1'b0);
    repeat (4) tick();
    chk("done_pulses", obs_dones, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
